// File: rtl/pc_fetch_sequencer.sv
// ============================================================================
//  Module      : pc_fetch_sequencer
//  Description : Next-PC controller for the pc register. Sequences the
//                instruction-memory fetch handshake, applies execute-stage
//                redirects, honours hazard stalls and holds o_flush for a
//                fixed number of cycles after every redirect.
//                Optional feature macro: IRQ_VEC_EN (adds i_irq / o_epc and
//                vectoring to IRQ_VEC).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch_sequencer #(
    parameter int               WIDTH        = 14,
    parameter logic [WIDTH-1:0] RESET_VEC    = 14'h2000,
    parameter logic [WIDTH-1:0] INC          = {{(WIDTH-1){1'b0}}, 1'b1},
`ifdef IRQ_VEC_EN
    parameter logic [WIDTH-1:0] IRQ_VEC      = 14'h3F00,
`endif
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_pc,
    output logic [WIDTH-1:0] o_pc_next,
    output logic             o_imem_req,
    output logic [WIDTH-1:0] o_imem_addr,
    input  logic             i_imem_ack,
    output logic             o_if_valid,
    input  logic             i_stall,
    input  logic             i_redirect,
    input  logic [WIDTH-1:0] i_redirect_target,
`ifdef IRQ_VEC_EN
    input  logic             i_irq,
    output logic [WIDTH-1:0] o_epc,
`endif
    output logic             o_flush
);

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    localparam logic [2:0] c_FLUSH_LOAD = 3'(FLUSH_CYCLES);

    logic [1:0]       r_state;
    logic [2:0]       r_cnt;
    logic             r_flush;

    logic [WIDTH-1:0] w_pc_next;
    logic             w_req;
    logic             w_valid;
    logic             w_take_redirect;
    logic             w_take_irq;
    logic             w_enter_flush;
    logic [2:0]       w_cnt_dec;

    assign o_pc_next     = w_pc_next;
    assign o_imem_req    = w_req;
    assign o_imem_addr   = i_pc;
    assign o_if_valid    = w_valid;
    assign o_flush       = r_flush;
    assign w_cnt_dec     = r_cnt - 3'd1;
    assign w_enter_flush = w_take_redirect | w_take_irq;

    // Next-PC, request and capture-strobe selection by state and priority
    always_comb begin
        w_pc_next       = i_pc;
        w_req           = 1'b0;
        w_valid         = 1'b0;
        w_take_redirect = 1'b0;
        w_take_irq      = 1'b0;
        case (r_state)
            S_RESET: begin
                w_pc_next = RESET_VEC;
            end
            S_FETCH: begin
                // The request drops whenever the PC cannot advance this cycle
                w_req = !i_stall && !i_redirect;
                if (i_redirect) begin
                    w_pc_next       = i_redirect_target;
                    w_take_redirect = 1'b1;
                end
`ifdef IRQ_VEC_EN
                else if (i_irq) begin
                    w_pc_next  = IRQ_VEC;
                    w_take_irq = 1'b1;
                end
`endif
                else if (i_stall) begin
                    w_pc_next = i_pc;
                end else if (i_imem_ack) begin
                    w_pc_next = i_pc + INC;
                    w_valid   = 1'b1;
                end
            end
            S_FLUSH: begin
                // Stray acks are discarded; only a new redirect moves the PC
                if (i_redirect) begin
                    w_pc_next       = i_redirect_target;
                    w_take_redirect = 1'b1;
                end
            end
            default: begin
                w_pc_next = RESET_VEC;
            end
        endcase
    end

    // State, flush counter and flush flag; the flag falls with the counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_RESET;
            r_cnt   <= 3'd0;
            r_flush <= 1'b0;
        end else begin
            case (r_state)
                S_RESET: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (w_enter_flush) begin
                        r_cnt   <= c_FLUSH_LOAD;
                        r_flush <= 1'b1;
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (w_take_redirect) begin
                        r_cnt   <= c_FLUSH_LOAD;
                        r_flush <= 1'b1;
                    end else begin
                        r_cnt   <= w_cnt_dec;
                        r_flush <= (w_cnt_dec != 3'd0);
                        if (w_cnt_dec == 3'd0) begin
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: begin
                    r_state <= S_RESET;
                    r_cnt   <= 3'd0;
                    r_flush <= 1'b0;
                end
            endcase
        end
    end

`ifdef IRQ_VEC_EN
    logic [WIDTH-1:0] r_epc;

    assign o_epc = r_epc;

    // Capture the interrupted fetch address when the interrupt is taken
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_epc <= RESET_VEC;
        end else if (w_take_irq) begin
            r_epc <= i_pc;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch_sequencer.sv
// ============================================================================
//  Module      : tb_pc_fetch_sequencer
//  Description : Self-checking bench for pc_fetch_sequencer: directed vector
//                table, hand-written corner sequences and a randomized run
//                against a behavioural model. Honours IRQ_VEC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch_sequencer;

    localparam logic [13:0] RST_V = 14'h2000;
    localparam logic [13:0] IRQ_V = 14'h3F00;
    localparam int          FC    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] pc_in = 14'h0;
    logic [13:0] pc_next;
    logic        req;
    logic [13:0] addr;
    logic        ack = 1'b0;
    logic        valid;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [13:0] tgt = 14'h0;
    logic        flush;
`ifdef IRQ_VEC_EN
    logic        irq = 1'b0;
    logic [13:0] epc;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pc_fetch_sequencer dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_pc              (pc_in),
        .o_pc_next         (pc_next),
        .o_imem_req        (req),
        .o_imem_addr       (addr),
        .i_imem_ack        (ack),
        .o_if_valid        (valid),
        .i_stall           (stall),
        .i_redirect        (redir),
        .i_redirect_target (tgt),
`ifdef IRQ_VEC_EN
        .i_irq             (irq),
        .o_epc             (epc),
`endif
        .o_flush           (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [13:0] tgt;
        logic        ack;
        logic [13:0] pc;
        logic [13:0] e_next;
        logic        e_req;
        logic        e_valid;
        logic        e_flush;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(input logic s, input logic r, input logic [13:0] t,
                                input logic a, input logic [13:0] p, input logic [13:0] en,
                                input logic er, input logic ev, input logic ef);
        vec_t v;
        v.stall = s; v.redir = r; v.tgt = t; v.ack = a; v.pc = p;
        v.e_next = en; v.e_req = er; v.e_valid = ev; v.e_flush = ef;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Asserts reset mid-cycle, checks reset outputs, releases during the high
    // phase so the following negedge sees the post-reset cycle.
    task automatic do_reset();
        @(negedge clk);
        stall = 1'b0; redir = 1'b0; ack = 1'b0;
`ifdef IRQ_VEC_EN
        irq = 1'b0;
`endif
        rst = 1'b1;
        #1;
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_pc_next", 32'(pc_next), 32'(RST_V));
        chk("rst_req", 32'(req), 32'd0);
`ifdef IRQ_VEC_EN
        chk("rst_epc", 32'(epc), 32'(RST_V));
`endif
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Model state for the randomized run
    bit          m_started;
    int          m_left;
    logic [13:0] m_pc;
    logic [13:0] m_epc;

    initial begin
        tbl[0]  = mk(0, 0, 14'h0,    0, 14'h2000, 14'h2000, 0, 0, 0);
        tbl[1]  = mk(0, 0, 14'h0,    1, 14'h2000, 14'h2001, 1, 1, 0);
        tbl[2]  = mk(0, 0, 14'h0,    1, 14'h2001, 14'h2002, 1, 1, 0);
        tbl[3]  = mk(0, 0, 14'h0,    1, 14'h2002, 14'h2003, 1, 1, 0);
        tbl[4]  = mk(0, 0, 14'h0,    0, 14'h2005, 14'h2005, 1, 0, 0);
        tbl[5]  = mk(0, 0, 14'h0,    0, 14'h2005, 14'h2005, 1, 0, 0);
        tbl[6]  = mk(0, 0, 14'h0,    0, 14'h2005, 14'h2005, 1, 0, 0);
        tbl[7]  = mk(0, 0, 14'h0,    1, 14'h2005, 14'h2006, 1, 1, 0);
        tbl[8]  = mk(1, 0, 14'h0,    1, 14'h2006, 14'h2006, 0, 0, 0);
        tbl[9]  = mk(1, 0, 14'h0,    1, 14'h2006, 14'h2006, 0, 0, 0);
        tbl[10] = mk(0, 0, 14'h0,    1, 14'h2006, 14'h2007, 1, 1, 0);
        tbl[11] = mk(0, 1, 14'h0100, 1, 14'h2010, 14'h0100, 0, 0, 0);
        tbl[12] = mk(0, 0, 14'h0,    1, 14'h0100, 14'h0100, 0, 0, 1);
        tbl[13] = mk(0, 0, 14'h0,    1, 14'h0100, 14'h0100, 0, 0, 1);
        tbl[14] = mk(0, 0, 14'h0,    1, 14'h0100, 14'h0101, 1, 1, 0);
        tbl[15] = mk(0, 0, 14'h0,    1, 14'h3FFF, 14'h0000, 1, 1, 0);
        tbl[16] = mk(0, 1, 14'h0200, 0, 14'h0000, 14'h0200, 0, 0, 0);
        tbl[17] = mk(1, 0, 14'h0,    0, 14'h0200, 14'h0200, 0, 0, 1);
        tbl[18] = mk(0, 1, 14'h0300, 0, 14'h0200, 14'h0300, 0, 0, 1);
        tbl[19] = mk(0, 0, 14'h0,    1, 14'h0300, 14'h0300, 0, 0, 1);
        tbl[20] = mk(0, 0, 14'h0,    0, 14'h0300, 14'h0300, 0, 0, 1);
        tbl[21] = mk(0, 0, 14'h0,    1, 14'h0300, 14'h0301, 1, 1, 0);

        // ---------------- directed vector table ----------------
        do_reset();
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            stall = tbl[i].stall; redir = tbl[i].redir; tgt = tbl[i].tgt;
            ack = tbl[i].ack; pc_in = tbl[i].pc;
            #1;
            chk($sformatf("v%0d_pc_next", i), 32'(pc_next), 32'(tbl[i].e_next));
            chk($sformatf("v%0d_req", i), 32'(req), 32'(tbl[i].e_req));
            chk($sformatf("v%0d_valid", i), 32'(valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_flush", i), 32'(flush), 32'(tbl[i].e_flush));
            chk($sformatf("v%0d_addr", i), 32'(addr), 32'(tbl[i].pc));
        end

        // ---------------- async reset in the middle of a flush ----------------
        @(negedge clk);
        stall = 1'b0; ack = 1'b0; redir = 1'b1; tgt = 14'h0555; pc_in = 14'h0301;
        @(negedge clk);
        redir = 1'b0; pc_in = 14'h0555;
        #1;
        chk("midflush_flush_before", 32'(flush), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midflush_flush_async", 32'(flush), 32'd0);
        chk("midflush_pc_next", 32'(pc_next), 32'(RST_V));
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        pc_in = 14'h1234;
        #1;
        chk("post_rst_pc_next", 32'(pc_next), 32'(RST_V));
        chk("post_rst_flush", 32'(flush), 32'd0);

`ifdef IRQ_VEC_EN
        // ---------------- interrupt sequences ----------------
        @(negedge clk);
        pc_in = 14'h2042; stall = 1'b1; irq = 1'b1; ack = 1'b1;
        #1;
        chk("irq_pc_next", 32'(pc_next), 32'(IRQ_V));
        chk("irq_valid", 32'(valid), 32'd0);
        @(negedge clk);
        stall = 1'b0; irq = 1'b0; pc_in = IRQ_V;
        #1;
        chk("irq_epc", 32'(epc), 32'h2042);
        chk("irq_flush1", 32'(flush), 32'd1);
        @(negedge clk);
        #1;
        chk("irq_flush2", 32'(flush), 32'd1);
        @(negedge clk);
        pc_in = 14'h2100; irq = 1'b1; redir = 1'b1; tgt = 14'h0777;
        #1;
        chk("irq_vs_redir_flush0", 32'(flush), 32'd0);
        chk("irq_vs_redir_pc_next", 32'(pc_next), 32'h0777);
        @(negedge clk);
        irq = 1'b0; redir = 1'b0; pc_in = 14'h0777;
        #1;
        chk("irq_vs_redir_epc", 32'(epc), 32'h2042);
        chk("irq_vs_redir_flush", 32'(flush), 32'd1);
`endif

        // ---------------- randomized run against behavioural model ----------------
        do_reset();
        m_started = 1'b0;
        m_left    = 0;
        m_pc      = RST_V;
        m_epc     = RST_V;
        for (int n = 0; n < 600; n++) begin
            logic [13:0] e_next;
            logic        e_req, e_valid, e_flush;
            logic        irq_now;
            @(negedge clk);
            stall = ($urandom_range(0, 4) == 0);
            redir = ($urandom_range(0, 11) == 0);
            tgt   = 14'($urandom);
            ack   = 1'($urandom_range(0, 1));
            pc_in = ($urandom_range(0, 19) == 0) ? 14'($urandom) : m_pc;
            if ($urandom_range(0, 29) == 0) pc_in = 14'h3FFF;
            irq_now = 1'b0;
`ifdef IRQ_VEC_EN
            irq = ($urandom_range(0, 15) == 0);
            irq_now = irq;
`endif
            #1;
            e_flush = (m_left > 0);
            e_req   = 1'b0;
            e_valid = 1'b0;
            e_next  = pc_in;
            if (!m_started) begin
                e_next    = RST_V;
                m_started = 1'b1;
            end else if (m_left > 0) begin
                if (redir) begin
                    e_next = tgt;
                    m_left = FC;
                end else begin
                    m_left = m_left - 1;
                end
            end else begin
                e_req = !stall && !redir;
                if (redir) begin
                    e_next = tgt;
                    m_left = FC;
                end else if (irq_now) begin
                    e_next = IRQ_V;
                    m_left = FC;
                end else if (!stall && ack) begin
                    e_next  = 14'((int'(pc_in) + 1) % 16384);
                    e_valid = 1'b1;
                end
            end
            chk("rnd_pc_next", 32'(pc_next), 32'(e_next));
            chk("rnd_req", 32'(req), 32'(e_req));
            chk("rnd_valid", 32'(valid), 32'(e_valid));
            chk("rnd_flush", 32'(flush), 32'(e_flush));
            chk("rnd_addr", 32'(addr), 32'(pc_in));
`ifdef IRQ_VEC_EN
            chk("rnd_epc", 32'(epc), 32'(m_epc));
            if (irq_now && !redir && e_next == IRQ_V && e_flush == 1'b0 && e_req == (!stall))
                m_epc = pc_in;
`endif
            m_pc = e_next;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
